// File: rtl/fifo_bank_l2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_bank_l2_pkg                                           |
// | Brief   : shared constants for the four-lane byte FIFO bank          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package fifo_bank_l2_pkg;
  localparam int DEPTH_DEFAULT     = 4;
  localparam int AF_THRESH_DEFAULT = 3;
  localparam int LANES             = 4;
  localparam int DATA_W            = 8;
endpackage
`default_nettype wire

// File: rtl/fifo_bank_l2_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_bank_l2_if                                            |
// | Brief   : lane-bundled push/pop/status signals of the FIFO bank      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface fifo_bank_l2_if;
  import fifo_bank_l2_pkg::*;

  logic [LANES-1:0]        validin;
  logic [LANES*DATA_W-1:0] datain;
  logic [LANES-1:0]        pop;
  logic [LANES*DATA_W-1:0] dataout;
  logic [LANES-1:0]        validout;
  logic [LANES-1:0]        empty;
  logic [LANES-1:0]        almost_full;
  logic [LANES-1:0]        err;

  modport master (
    output validin, datain, pop,
    input  dataout, validout, empty, almost_full, err
  );

  modport slave (
    input  validin, datain, pop,
    output dataout, validout, empty, almost_full, err
  );
endinterface
`default_nettype wire

// File: rtl/fifo_bank_l2_fifo_8b.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_8b                                                    |
// | Brief   : single-lane byte FIFO, registered read port, latency 1.    |
// |           Macro FIFO_BANK_L2_ERR_EN enables the sticky err flag.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fifo_8b
  import fifo_bank_l2_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEFAULT,
  parameter int AF_THRESH = AF_THRESH_DEFAULT
) (
  input  wire logic              clk,
  input  wire logic              reset_L,
  input  wire logic              validin,
  input  wire logic [DATA_W-1:0] datain,
  input  wire logic              pop,
  output logic      [DATA_W-1:0] dataout,
  output logic                   validout,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              validout_q, validout_d;
  logic              push_ok, pop_ok;

  // Full/empty are judged on the pre-edge count, so an empty lane never
  // forwards a same-cycle push and a full lane drops a same-cycle push.
  always_comb begin
    push_ok    = validin && (count_q < C_DEPTH);
    pop_ok     = pop && (count_q != '0);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dataout_d  = dataout_q;
    validout_d = pop_ok;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      dataout_d = mem_q[rd_ptr_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dataout_q  <= '0;
      validout_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dataout_q  <= dataout_d;
      validout_q <= validout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= datain;
  end

`ifdef FIFO_BANK_L2_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (validin && !push_ok) | (pop && !pop_ok);
  end

  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign dataout     = dataout_q;
  assign validout    = validout_q;
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= C_AF);
endmodule
`default_nettype wire

// File: rtl/fifo_bank_l2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_bank_l2                                               |
// | Brief   : four independent byte FIFOs, one per demux lane.           |
// |           Macro FIFO_BANK_L2_ERR_EN enables per-lane err flags.      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fifo_bank_l2
  import fifo_bank_l2_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEFAULT,
  parameter int AF_THRESH = AF_THRESH_DEFAULT
) (
  input wire logic        clk,
  input wire logic        reset_L,
  fifo_bank_l2_if.slave   bus
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fifo_8b #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
    ) u_fifo (
      .clk         (clk),
      .reset_L     (reset_L),
      .validin     (bus.validin[i]),
      .datain      (bus.datain[DATA_W*i +: DATA_W]),
      .pop         (bus.pop[i]),
      .dataout     (bus.dataout[DATA_W*i +: DATA_W]),
      .validout    (bus.validout[i]),
      .empty       (bus.empty[i]),
      .almost_full (bus.almost_full[i]),
      .err         (bus.err[i])
    );
  end
endmodule
`default_nettype wire

// File: tb/tb_fifo_bank_l2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fifo_bank_l2                                            |
// | Brief   : queue-model bench with directed and random lane traffic    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_fifo_bank_l2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic clk = 1'b0;
  logic reset_L = 1'b1;
  bit   done = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  fifo_bank_l2_if io();

  fifo_bank_l2 #(.DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (io)
  );

  always #5 clk = ~clk;

  logic [7:0] mq [4][$];
  logic [7:0] exp_dout [4];
  logic       exp_vout [4];
  logic       exp_err  [4];

  task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lane %0d: got %0h want %0h", name, lane, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      exp_dout[i] = 8'h00;
      exp_vout[i] = 1'b0;
      exp_err[i]  = 1'b0;
    end
  endtask

  // Reference: each lane is a bounded queue; decisions use the pre-edge size.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset_L) begin
        for (int i = 0; i < 4; i++) begin
          bit do_push, do_pop;
          do_push = io.validin[i] && (mq[i].size() < DEPTH);
          do_pop  = io.pop[i] && (mq[i].size() > 0);
`ifdef FIFO_BANK_L2_ERR_EN
          if ((io.validin[i] && !do_push) || (io.pop[i] && !do_pop)) exp_err[i] = 1'b1;
`endif
          exp_vout[i] = do_pop;
          if (do_pop) exp_dout[i] = mq[i].pop_front();
          if (do_push) mq[i].push_back(io.datain[8*i +: 8]);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) break;
      for (int i = 0; i < 4; i++) begin
        chk("dataout", i, 32'(io.dataout[8*i +: 8]), 32'(exp_dout[i]));
        chk("validout", i, 32'(io.validout[i]), 32'(exp_vout[i]));
        chk("empty", i, 32'(io.empty[i]), 32'(mq[i].size() == 0));
        chk("almost_full", i, 32'(io.almost_full[i]), 32'(mq[i].size() >= AF));
        chk("err", i, 32'(io.err[i]), 32'(exp_err[i]));
      end
    end
  end

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] p);
    @(negedge clk);
    io.validin = v;
    io.datain  = d;
    io.pop     = p;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    io.validin = '0;
    io.datain  = '0;
    io.pop     = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", 0, 32'(io.empty), 32'hF);
    chk("rst_vout", 0, 32'(io.validout), 32'h0);
    @(negedge clk);
    reset_L = 1'b0;

    // lane 0: three pushes, three pops
    drive(4'h1, 32'hA1, 4'h0); settle();
    drive(4'h1, 32'hA2, 4'h0); settle();
    drive(4'h1, 32'hA3, 4'h0); settle();
    for (int k = 0; k < 3; k++) begin
      drive(4'h0, 32'h0, 4'h1); settle();
      chk("l0_pop_data", 0, 32'(io.dataout[7:0]), 32'hA1 + 32'(k));
      chk("l0_pop_valid", 0, 32'(io.validout[0]), 32'h1);
    end
    drive(4'h0, 32'h0, 4'h0); settle();
    chk("l0_empty_after", 0, 32'(io.empty[0]), 32'h1);
    chk("l0_valid_drop", 0, 32'(io.validout[0]), 32'h0);

    // lane 2: overfill by one
    for (int k = 0; k < 5; k++) begin
      drive(4'h4, 32'(8'h10 + k) << 16, 4'h0); settle();
      if (k == 2) chk("l2_af_at3", 2, 32'(io.almost_full[2]), 32'h1);
    end
`ifdef FIFO_BANK_L2_ERR_EN
    chk("l2_err_drop", 2, 32'(io.err[2]), 32'h1);
`else
    chk("l2_err_off", 2, 32'(io.err[2]), 32'h0);
`endif

    // lane 1: full, push+pop same cycle
    for (int k = 0; k < 4; k++) begin
      drive(4'h2, 32'(8'h20 + k) << 8, 4'h0); settle();
    end
    drive(4'h2, 32'hFF << 8, 4'h2); settle();
    chk("l1_full_pp_data", 1, 32'(io.dataout[15:8]), 32'h20);
    chk("l1_full_pp_af", 1, 32'(io.almost_full[1]), 32'h1);
    for (int k = 1; k < 4; k++) begin
      drive(4'h0, 32'h0, 4'h2); settle();
      chk("l1_drain", 1, 32'(io.dataout[15:8]), 32'h20 + 32'(k));
    end
    drive(4'h0, 32'h0, 4'h2); settle();
    chk("l1_ff_dropped", 1, 32'(io.validout[1]), 32'h0);

    // lane 3: empty, push+pop same cycle -> no fall-through
    drive(4'h8, 32'h5A << 24, 4'h8); settle();
    chk("l3_no_fallthru", 3, 32'(io.validout[3]), 32'h0);
    chk("l3_occ1", 3, 32'(io.empty[3]), 32'h0);
    drive(4'h0, 32'h0, 4'h8); settle();
    chk("l3_pop_5a", 3, 32'(io.dataout[31:24]), 32'h5A);

    // lane 0: stream 0..19 through wraps
    for (int k = 0; k < 20; k++) begin
      drive(4'h1, 32'(k), 4'h1); settle();
      if (k == 0) chk("l0_stream_first", 0, 32'(io.validout[0]), 32'h0);
      else        chk("l0_stream", 0, 32'(io.dataout[7:0]), 32'(k - 1));
    end
    drive(4'h0, 32'h0, 4'h1); settle();
    chk("l0_stream_last", 0, 32'(io.dataout[7:0]), 32'd19);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      drive(4'($urandom), $urandom, 4'($urandom));
    end

    // leave lanes partially full, then reset without a clock edge
    drive(4'h0, 32'h0, 4'hF);
    drive(4'h0, 32'h0, 4'hF);
    drive(4'h0, 32'h0, 4'hF);
    drive(4'h0, 32'h0, 4'hF);
    drive(4'hF, $urandom, 4'h0);
    drive(4'hF, $urandom, 4'h0);
    drive(4'h0, 32'h0, 4'h0);
    @(posedge clk);
    #2;
    chk("pre_rst_full", 0, 32'(io.empty), 32'h0);
    reset_L = 1'b1;
    model_clear();
    #1;
    chk("arst_dout", 0, io.dataout, 32'h0);
    chk("arst_vout", 0, 32'(io.validout), 32'h0);
    chk("arst_empty", 0, 32'(io.empty), 32'hF);
    chk("arst_af", 0, 32'(io.almost_full), 32'h0);
    chk("arst_err", 0, 32'(io.err), 32'h0);
    repeat (2) @(negedge clk);
    reset_L = 1'b0;
    io.pop = 4'hF;
    settle();
    chk("post_rst_pop", 0, 32'(io.validout), 32'h0);
    drive(4'hF, 32'h44332211, 4'h0); settle();
    chk("post_rst_push", 0, 32'(io.empty), 32'h0);
    drive(4'h0, 32'h0, 4'hF); settle();
    chk("post_rst_data", 0, io.dataout, 32'h44332211);
    drive(4'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);

    done = 1'b1;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fifo_bank_l2.md
FIFO_BANK_L2 -- requirements
Module: fifo_bank_l2

Interface
REQ-001 Parameter DEPTH, default 4: entries per lane FIFO, power of two, 2..16.
REQ-002 Parameter AF_THRESH, default 3: occupancy at or above which almost_full asserts.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_L  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-005 validin  input  4  lane i write strobe, driven by upstream demux validout0..3.
REQ-006 datain  input  32  lane i byte at bits [8i+7:8i], driven by upstream demux dataout0..3.
REQ-007 pop  input  4  lane i read request from downstream consumer.
REQ-008 dataout  output  32  lane i read byte at bits [8i+7:8i], registered.
REQ-009 validout  output  4  lane i dataout qualifier, registered, one-cycle pulse per pop.
REQ-010 empty  output  4  lane i occupancy == 0, combinational from state.
REQ-011 almost_full  output  4  lane i occupancy >= AF_THRESH, combinational from state.
REQ-012 err  output  4  lane i sticky error flag (present only per REQ-028).

Function
REQ-013 Lanes SHALL be fully independent; no shared state between lanes.
REQ-014 Push on lane i SHALL occur when validin[i]=1 and lane occupancy < DEPTH, writing datain byte at write pointer.
REQ-015 Push when occupancy == DEPTH SHALL be dropped; FIFO contents, pointers unchanged.
REQ-016 Pop on lane i SHALL occur when pop[i]=1 and occupancy > 0; byte at read pointer appears on dataout with validout[i]=1 on the following cycle (latency 1).
REQ-017 Pop when empty SHALL be ignored; validout[i]=0 next cycle; dataout holds previous value.
REQ-018 Full/empty SHALL be evaluated on pre-edge occupancy: push+pop while full drops the push and performs the pop; push+pop while empty performs the push only (no fall-through).
REQ-019 Push+pop with 0 < occupancy < DEPTH SHALL both occur; occupancy unchanged.
REQ-020 Pointers SHALL be log2(DEPTH) bits and wrap DEPTH-1 -> 0; occupancy counter log2(DEPTH)+1 bits.
REQ-021 Order SHALL be strict FIFO per lane across any number of wraps.
REQ-022 validout[i] SHALL deassert the cycle after a cycle with no successful pop.

Reset
REQ-023 While reset_L=1: pointers and occupancy 0, dataout=0, validout=0, err=0; empty=4'hF, almost_full=0.
REQ-024 Reset asserted mid-operation SHALL discard all stored bytes immediately (asynchronous).
REQ-025 First push/pop SHALL be honoured on the first rising edge after reset_L deasserts.
REQ-026 Storage array contents need not be reset.

Configuration
REQ-027 Macro FIFO_BANK_L2_ERR_EN controls error reporting.
REQ-028 Defined: err[i] sets on a dropped push (REQ-015) or ignored pop (REQ-017) and holds until reset. Undefined: err port tied to 0 and no error logic synthesized.

Structure
REQ-029 Shared package holds DEPTH and AF_THRESH defaults, lane count (4) and data width (8) constants.
REQ-030 One sub-module fifo_8b (single-lane FIFO, same parameters) SHALL be instantiated four times; top contains only instantiation and bit slicing.

Verification
REQ-031 Reset then push 8'hA1,8'hA2,8'hA3 on lane 0, pop x3 -> dataout[7:0]=A1,A2,A3 on consecutive cycles after each pop, validout[0]=1 each, empty[0]=1 after.
REQ-032 Push 5 bytes 8'h10..8'h14 on lane 2 with no pop -> 10..13 stored, 14 dropped, almost_full[2]=1 at occupancy 3, err[2]=1 (ERR_EN defined).
REQ-033 Full lane 1 with push 8'hFF and pop same cycle -> oldest byte out, FF dropped, occupancy 3.
REQ-034 Empty lane 3 with push 8'h5A and pop same cycle -> validout[3]=0 next cycle, occupancy 1; next pop returns 5A.
REQ-035 Stream 20 bytes 0..19 through lane 0 with push/pop every cycle -> output 0..19 in order across pointer wraps.
REQ-036 Assert reset_L mid-stream with lanes partially full -> all outputs at reset values without a clock edge; pop after release -> validout=0.
